alu_nibble_seq: RTL
===================

# alu_nibble_seq

Nibble-serial 8-bit add/subtract stage for the 8-bit ALU. It accepts two 8-bit operands and an opcode over a valid/ready handshake. It drives a single 4-bit carry-lookahead adder twice, low nibble first, holding the inter-nibble carry in a register. The block sits directly upstream of the 4-bit adder, sequencing its operands and carry-in, and presents the assembled 8-bit result and flags to the ALU output mux.

## Interface
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand/opcode valid
- `in_ready`  out  1  block can accept a request
- `a`  in  8  operand A
- `b`  in  8  operand B
- `op`  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB
- `cin`  in  1  carry-in for ADC; borrow-in for SBB; ignored for ADD/SUB
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `result`  out  8  sum/difference
- `cout`  out  1  carry-out; for SUB/SBB, 1 = no borrow
- `ovf`  out  1  signed overflow
- `zero`  out  1  result == 0

## Operation
- Effective operand: `bx = b` for ADD/ADC, `bx = ~b` for SUB/SBB.
- Effective carry-in `c0`:
  - ADD: 0
  - SUB: 1
  - ADC: `cin`
  - SBB: `~cin`
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid&&in_ready`, register `a`, `bx` and `c0`, then go to LO.
- LO:
  - Adder computes `a[3:0]+bx[3:0]+c0`.
  - Register `sum[3:0]` and the nibble carry `c4`, then go to HI.
- HI:
  - Adder computes `a[7:4]+bx[7:4]+c4`.
  - Register `sum[7:4]`, `cout`, and the flags, then go to DONE.
- DONE:
  - `out_valid=1`. Outputs are held stable while `out_ready=0`.
  - On `out_ready`, go to IDLE.
- `ovf = (a[7]==bx[7]) && (result[7]!=a[7])`, computed on the effective operand.
- All arithmetic is modulo 2^8. Carry beyond bit 8 exists only as `cout`.
- Reset at any point, including mid-operation:
  - FSM goes to IDLE and the in-flight request is discarded.
  - `in_ready=1`, `out_valid=0`, `result=0x00`, `cout=0`, `ovf=0`, `zero=0`.
  - Operand and carry registers clear to 0.

## Timing
- Accept at edge N. Low nibble is registered at N+1, high nibble at N+2. `out_valid` is asserted after edge N+2, giving 3-cycle latency.
- Peak throughput: one operation per 4 cycles. IDLE is mandatory; there is no accept in DONE.
- `in_ready` is high only in IDLE.
- `result`, `cout`, `ovf` and `zero` are registered outputs. They change only on the HI→DONE edge or on reset.
- Inputs `a`, `b`, `op` and `cin` are sampled only on the accept edge. Later changes have no effect.
- `out_ready` high outside DONE is ignored.
- `in_valid` outside IDLE is ignored. The request is not lost: the upstream holds it per the handshake.

## Configuration
- Macro: `ALU_NIBBLE_SEQ_FLAGS_EN`.
- Defined: `ovf` and `zero` are computed and registered as above.
- Undefined: flag logic is not synthesised and `ovf=0`, `zero=0` constantly. `cout` and `result` are unaffected, and the port list is unchanged.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode encodings (`ALU_OP_ADD`, `ALU_OP_SUB`, `ALU_OP_ADC`, `ALU_OP_SBB`);
  - the FSM state enum (IDLE, LO, HI, DONE).
- One sub-module: `alu_nibble_cla`, a combinational 4-bit carry-lookahead adder (inputs A[3:0], B[3:0], cin; outputs sum[3:0], cout).
  - Instantiate it exactly once.
  - The nibble mux in front of it is selected by FSM state.

## Test plan
- ADD a=0x3A, b=0x4C:
  - `out_valid` rises 3 cycles after accept.
  - Expect `result=0x86`, `cout=0`, `ovf=1`, `zero=0`.
- ADD a=0xFF, b=0x01:
  - Expect `result=0x00`, `cout=1`, `ovf=0`, `zero=1`.
- SUB a=0x10, b=0x01:
  - Expect `result=0x0F`, `cout=1`, `ovf=0`.
  - This exercises the inter-nibble borrow path.
- ADC a=0x0F, b=0x00, cin=1:
  - Expect `result=0x10`, `cout=0`.
- SBB a=0x00, b=0x00, cin=1:
  - Expect `result=0xFF`, `cout=0`, `ovf=0`.
- Backpressure and mid-operation reset:
  - Hold `out_ready=0` for 5 cycles in DONE: outputs are stable and `in_ready=0` throughout.
  - Assert `rst_n=0` during LO, then release: all outputs are at reset values and `in_ready=1`.
  - The next ADD 0x01+0x01 then yields `result=0x02`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the nibble sequencer states.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'b00,
        ALU_OP_SUB = 2'b01,
        ALU_OP_ADC = 2'b10,
        ALU_OP_SBB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        DONE = 2'b11
    } alu_state_e;

endpackage

// File: rtl/alu_nibble_seq_if.sv
// Request/response handshake bundle for the nibble-serial add/sub stage.
interface alu_nibble_seq_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       cout;
    logic       ovf;
    logic       zero;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );

endinterface

// File: rtl/alu_nibble_cla.sv
// Combinational 4-bit carry-lookahead adder shared by both nibble passes.
module alu_nibble_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial 8-bit ADD/SUB/ADC/SBB over one 4-bit CLA, low nibble first.
// Define ALU_NIBBLE_SEQ_FLAGS_EN to build the ovf/zero flag logic.
module alu_nibble_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_nibble_seq_if.slave   bus
);

    alu_state_e state_q;
    alu_state_e state_d;
    alu_op_e    op_e;

    logic [7:0] a_q;
    logic [7:0] bx_q;
    logic       c_q;
    logic [3:0] lo_q;
    logic [7:0] res_q;
    logic       cout_q;

    logic [7:0] bx_in;
    logic       c0;
    logic [3:0] na;
    logic [3:0] nb;
    logic [3:0] s;
    logic       co;

    assign op_e  = alu_op_e'(bus.op);
    assign bx_in = bus.op[0] ? ~bus.b : bus.b;

    always_comb begin
        c0 = 1'b0;
        unique case (1'b1)
            op_e == ALU_OP_ADD: c0 = 1'b0;
            op_e == ALU_OP_SUB: c0 = 1'b1;
            op_e == ALU_OP_ADC: c0 = bus.cin;
            op_e == ALU_OP_SBB: c0 = ~bus.cin;
            default:            c0 = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Nibble mux in front of the shared adder follows the FSM state.
    always_comb begin
        state_d = state_q;
        na      = a_q[3:0];
        nb      = bx_q[3:0];
        case (state_q)
            IDLE: if (bus.in_valid) state_d = LO;
            LO:   state_d = HI;
            HI: begin
                na      = a_q[7:4];
                nb      = bx_q[7:4];
                state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    alu_nibble_cla u_cla (
        .a    (na),
        .b    (nb),
        .cin  (c_q),
        .sum  (s),
        .cout (co)
    );

    // c_q carries c0 into LO, then the nibble carry c4 into HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= 8'h00;
            bx_q   <= 8'h00;
            c_q    <= 1'b0;
            lo_q   <= 4'h0;
            res_q  <= 8'h00;
            cout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q  <= bus.a;
                    bx_q <= bx_in;
                    c_q  <= c0;
                end
                LO: begin
                    lo_q <= s;
                    c_q  <= co;
                end
                HI: begin
                    res_q  <= {s, lo_q};
                    cout_q <= co;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state_q == HI) begin
            ovf_q  <= (a_q[7] == bx_q[7]) && (s[3] != a_q[7]);
            zero_q <= ({s, lo_q} == 8'h00);
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;

endmodule
